// File: rtl/dmem_pkg.sv
// Shared widths, FSM encoding and request payload for the data-memory arbiter.
package dmem_pkg;

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned DATA_W = 48;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              read;
        logic              write;
    } req_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports, the memory port and the busy flag.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic [ADDR_W-1:0] m0_addr;
    logic              m0_read;
    logic              m0_write;
    logic [DATA_W-1:0] m0_wdata;
    logic [DATA_W-1:0] m0_rdata;
    logic              m0_done;

    logic [ADDR_W-1:0] m1_addr;
    logic              m1_read;
    logic              m1_write;
    logic [DATA_W-1:0] m1_wdata;
    logic [DATA_W-1:0] m1_rdata;
    logic              m1_done;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;

    logic              busy;

    // Arbiter side
    modport slave (
        input  m0_addr, m0_read, m0_write, m0_wdata,
        input  m1_addr, m1_read, m1_write, m1_wdata,
        input  mem_rdata, mem_done,
        output m0_rdata, m0_done, m1_rdata, m1_done,
        output mem_addr, mem_read, mem_write, mem_wdata, busy
    );

    // Requesters plus memory side
    modport master (
        output m0_addr, m0_read, m0_write, m0_wdata,
        output m1_addr, m1_read, m1_write, m1_wdata,
        output mem_rdata, mem_done,
        input  m0_rdata, m0_done, m1_rdata, m1_done,
        input  mem_addr, mem_read, mem_write, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way grant picker: round-robin on contention or fixed port-0 priority.
module rr_arb2 #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant_c
);

    // last=1 means port 1 was served most recently, so port 0 is next in line
    always_comb begin
        grant_c = req;
        if (req == 2'b11) begin
            grant_c = (ROUND_ROBIN && !last) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Serialises CPU (port 0) and I/O (port 1) word accesses onto the data memory.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input logic           clk,
    input logic           reset_n,
    dmem_arbiter_if.slave bus
);

    state_e            state_q, state_d;
    logic              last_q, last_d;
    logic              owner_q, owner_d;
    req_t              req_q, req_d;
    req_t              m0_req_c, m1_req_c;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic              busy_q, busy_d;
    logic [1:0]        req_c, grant_c;

    assign m0_req_c = '{addr: bus.m0_addr, wdata: bus.m0_wdata,
                        read: bus.m0_read, write: bus.m0_write};
    assign m1_req_c = '{addr: bus.m1_addr, wdata: bus.m1_wdata,
                        read: bus.m1_read, write: bus.m1_write};
    assign req_c    = {m1_req_c.read | m1_req_c.write, m0_req_c.read | m0_req_c.write};

    rr_arb2 #(
        .ROUND_ROBIN(ROUND_ROBIN)
    ) u_arb (
        .req    (req_c),
        .last   (last_q),
        .grant_c(grant_c)
    );

    // Next-state and next-output logic; req_q.read/write double as the strobes
    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        owner_d  = owner_q;
        req_d    = req_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;

        req_d.read  = 1'b0;
        req_d.write = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (|req_c) begin
                    req_d   = grant_c[0] ? m0_req_c : m1_req_c;
                    owner_d = grant_c[1];
                    last_d  = grant_c[1];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_done) begin
                    if (owner_q) begin
                        rdata1_d = bus.mem_rdata;
                        done1_d  = 1'b1;
                    end else begin
                        rdata0_d = bus.mem_rdata;
                        done0_d  = 1'b1;
                    end
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            owner_q  <= 1'b0;
            req_q    <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            owner_q  <= owner_d;
            req_q    <= req_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    assign bus.mem_addr  = req_q.addr;
    assign bus.mem_wdata = req_q.wdata;
    assign bus.mem_read  = req_q.read;
    assign bus.mem_write = req_q.write;
    assign bus.m0_rdata  = rdata0_q;
    assign bus.m1_rdata  = rdata1_q;
    assign bus.m0_done   = done0_q;
    assign bus.m1_done   = done1_q;
    assign bus.busy      = busy_q;

endmodule
